// File: rtl/icache_inv_issuer.sv
// icache_inv_issuer: buffers snoop/write addresses and issues line invalidations to the I-cache one at a time.
// Optional macro ICACHE_INV_COALESCE_EN drops offered lines already waiting in the FIFO.
module icache_inv_issuer #(
    parameter int FIFO_DEPTH      = 4,
    parameter int SUB_LINE_ADDR_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snoop_valid_i,
    input  logic [31:0] snoop_addr_i,
    output logic        snoop_ready_o,
    output logic        extern_inv_o,
    output logic [31:0] inv_addr_o,
    input  logic        extern_inv_complete_i,
    output logic        inv_idle_o,
    output logic        coalesce_hit_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int LSB = SUB_LINE_ADDR_W + 2;
    localparam logic [31:0] LOW_MASK = 32'((64'd1 << LSB) - 64'd1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          extern_inv_q, extern_inv_d;
    logic [31:0]   inv_addr_q, inv_addr_d;
    logic [31:0]   line_addr;
    logic          accept, dup, push, pop;

    assign line_addr      = snoop_addr_i & ~LOW_MASK;
    assign snoop_ready_o  = count_q != CW'(FIFO_DEPTH);
    assign accept         = snoop_valid_i & snoop_ready_o;
    assign push           = accept & ~dup;
    assign pop            = (state_q == IDLE) && (count_q != '0);
    assign coalesce_hit_o = accept & dup;
    assign extern_inv_o   = extern_inv_q;
    assign inv_addr_o     = inv_addr_q;
    assign inv_idle_o     = (state_q == IDLE) && (count_q == '0);

`ifdef ICACHE_INV_COALESCE_EN
    // Only entries still in the FIFO are compared; the in-flight line was already popped.
    always_comb begin
        dup = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++)
            dup = dup | ((CW'(k) < count_q) && (mem_q[head_q + PW'(k)] == line_addr));
    end
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        extern_inv_d = extern_inv_q;
        inv_addr_d   = inv_addr_q;
        state_d      = (state_q == IDLE)  ? (pop ? ISSUE : IDLE) :
                       (state_q == ISSUE) ? (extern_inv_complete_i ? GAP : ISSUE) : IDLE;
        extern_inv_d = state_d == ISSUE;
        inv_addr_d   = pop ? mem_q[head_q] : inv_addr_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= line_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            extern_inv_q <= 1'b0;
            inv_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= pop ? head_q + 1'b1 : head_q;
            tail_q       <= push ? tail_q + 1'b1 : tail_q;
            count_q      <= count_q + CW'(push) - CW'(pop);
            extern_inv_q <= extern_inv_d;
            inv_addr_q   <= inv_addr_d;
        end
    end
endmodule

// File: tb/tb_icache_inv_issuer.sv
// tb_icache_inv_issuer: random and directed stimulus checked against a queue-based model of the issuer.
module tb_icache_inv_issuer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snoop_valid = 1'b0;
    logic [31:0] snoop_addr = '0;
    logic        complete = 1'b0;
    logic        snoop_ready, extern_inv, inv_idle, coalesce_hit;
    logic [31:0] inv_addr;

    icache_inv_issuer dut (
        .clk(clk), .rst_n(rst_n),
        .snoop_valid_i(snoop_valid), .snoop_addr_i(snoop_addr), .snoop_ready_o(snoop_ready),
        .extern_inv_o(extern_inv), .inv_addr_o(inv_addr),
        .extern_inv_complete_i(complete), .inv_idle_o(inv_idle), .coalesce_hit_o(coalesce_hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;

    // Model: pending lines in arrival order, the line being invalidated, and edges since the last completion.
    logic [31:0] q[$];
    logic [31:0] cur = '0;
    bit          inflight = 0;
    int          settle = 9;
    logic        prev_ext = 1'b0;
    logic [31:0] dut_issued[$];

    function automatic logic [31:0] line(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

    function automatic bit pending(input logic [31:0] a);
        foreach (q[i]) if (q[i] == a) return 1;
        return 0;
    endfunction

    task automatic step(input logic v, input logic [31:0] a, input logic c);
        bit exp_ready, exp_idle, dup, acc, issue;
        @(negedge clk);
        snoop_valid = v;
        snoop_addr = a;
        complete = c;
        #1;
        exp_ready = q.size() != 4;
        exp_idle = !inflight && settle >= 1 && q.size() == 0;
`ifdef ICACHE_INV_COALESCE_EN
        dup = v && pending(line(a));
`else
        dup = 0;
`endif
        acc = v && exp_ready;
        checks++;
        if (snoop_ready !== exp_ready) begin
            fails++;
            $display("FAIL snoop_ready: got %b expected %b", snoop_ready, exp_ready);
        end
        checks++;
        if (extern_inv !== inflight) begin
            fails++;
            $display("FAIL extern_inv: got %b expected %b", extern_inv, inflight);
        end
        if (inflight) begin
            checks++;
            if (inv_addr !== cur) begin
                fails++;
                $display("FAIL inv_addr: got %h expected %h", inv_addr, cur);
            end
        end
        checks++;
        if (inv_idle !== exp_idle) begin
            fails++;
            $display("FAIL inv_idle: got %b expected %b", inv_idle, exp_idle);
        end
        checks++;
        if (coalesce_hit !== (acc && dup)) begin
            fails++;
            $display("FAIL coalesce_hit: got %b expected %b", coalesce_hit, acc && dup);
        end
        if (extern_inv === 1'b1 && prev_ext !== 1'b1) dut_issued.push_back(inv_addr);
        prev_ext = extern_inv;
        @(posedge clk);
        issue = !inflight && settle >= 1 && q.size() > 0;
        if (inflight && c) begin
            inflight = 0;
            settle = 0;
        end else if (settle < 9) settle++;
        if (issue) begin
            cur = q.pop_front();
            inflight = 1;
        end
        if (acc && !dup) q.push_back(line(a));
    endtask

    task automatic run(input int n, input int pct);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'($urandom_range(99) < pct));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        snoop_valid = 1'b0;
        complete = 1'b0;
        rst_n = 1'b0;
        #1;
        q.delete();
        inflight = 0;
        settle = 9;
        prev_ext = 1'b0;
        checks++;
        if (extern_inv !== 1'b0 || inv_addr !== 32'h0 || snoop_ready !== 1'b1 || inv_idle !== 1'b1 || coalesce_hit !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got inv=%b addr=%h rdy=%b idle=%b hit=%b expected 0 0 1 1 0",
                     extern_inv, inv_addr, snoop_ready, inv_idle, coalesce_hit);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        run(3, 0);
    endtask

    task automatic test_latency();
        apply_reset();
        step(1'b1, 32'h0000_1234, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        #2;
        checks++;
        if (extern_inv !== 1'b1 || inv_addr !== 32'h0000_1220) begin
            fails++;
            $display("FAIL latency: got inv=%b addr=%h expected 1 00001220", extern_inv, inv_addr);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        #2;
        checks++;
        if (extern_inv !== 1'b0 || inv_idle !== 1'b0) begin
            fails++;
            $display("FAIL gap_cycle: got inv=%b idle=%b expected 0 0", extern_inv, inv_idle);
        end
        step(1'b0, 32'h0, 1'b0);
        #2;
        checks++;
        if (inv_idle !== 1'b1) begin
            fails++;
            $display("FAIL idle_after_gap: got %b expected 1", inv_idle);
        end
        run(2, 0);
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'h0000_2000 + 32'(i) * 32'h40, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_3000, 1'b0);
        checks++;
        if (snoop_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_ready: got %b expected 0", snoop_ready);
        end
        step(1'b1, 32'h0000_3000, 1'b1);
        run(40, 50);
    endtask

    task automatic test_ignored_complete();
        apply_reset();
        run(4, 100);
        step(1'b1, 32'h0000_5000, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        run(3, 0);
        step(1'b0, 32'h0, 1'b1);
        run(2, 100);
        run(6, 0);
    endtask

    task automatic test_coalesce();
        logic [31:0] exp_list[$];
        apply_reset();
        dut_issued.delete();
        step(1'b1, 32'h0000_0200, 1'b0);
        run(2, 0);
        step(1'b1, 32'h0000_0100, 1'b0);
        step(1'b1, 32'h0000_0104, 1'b0);
        step(1'b1, 32'h0000_0140, 1'b0);
        step(1'b1, 32'h0000_0200, 1'b0);
        run(60, 50);
`ifdef ICACHE_INV_COALESCE_EN
        exp_list = '{32'h200, 32'h100, 32'h140, 32'h200};
`else
        exp_list = '{32'h200, 32'h100, 32'h100, 32'h140, 32'h200};
`endif
        checks++;
        if (dut_issued.size() != exp_list.size()) begin
            fails++;
            $display("FAIL issue_count: got %0d expected %0d", dut_issued.size(), exp_list.size());
        end else begin
            foreach (exp_list[i]) begin
                checks++;
                if (dut_issued[i] !== exp_list[i]) begin
                    fails++;
                    $display("FAIL issue_order[%0d]: got %h expected %h", i, dut_issued[i], exp_list[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_issue();
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_6000 + 32'(i) * 32'h20, 1'b0);
        apply_reset();
        run(10, 30);
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(1)), 32'h0000_4000 + 32'($urandom_range(7)) * 32'h20 + 32'($urandom_range(31)),
                 1'($urandom_range(99) < 30));
        run(60, 50);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_full();
        test_ignored_complete();
        test_coalesce();
        test_reset_mid_issue();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
